// File: rtl/image_uart_dump.sv
// Image store readback: fetches every pixel over the shared RAM port and streams it out as
// 8N1 UART bytes (header byte, then {4'h0, pix[11:8]} and pix[7:0] per pixel).
`timescale 1ns / 1ps

module image_uart_dump #(
    parameter int unsigned W       = 3,
    parameter int unsigned H       = 2,
    parameter int unsigned CLK_DIV = 434,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        spram_rd_req,
    input  logic        spram_rd_gnt,
    output logic [14:0] spram_addr,
    input  logic [11:0] spram_rd_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done,
    output logic [14:0] pix_cnt
);

    localparam int unsigned NPix    = W * H;
    localparam int unsigned BaudW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);
    localparam logic [15:0] NPixL   = 16'(NPix);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StFetch,
        StWait,
        StSendHi,
        StSendLo,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [14:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       cnt_inc;
    logic [11:0]       pix_q, pix_d;
    logic              tx_active_q, tx_active_d;
    logic [3:0]        bit_q, bit_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [9:0]        shift_q, shift_d;
    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              tx_done;

    // Serializer: shift_q holds {stop, data, start}; bit 0 drives the line.
    always_comb begin
        tx_active_d = tx_active_q;
        bit_d       = bit_q;
        baud_d      = baud_q;
        shift_d     = shift_q;
        tx_done     = tx_active_q && (baud_q == BaudMax) && (bit_q == 4'd9);
        if (tx_active_q) begin
            if (baud_q == BaudMax) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    tx_active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
        // A load in the last stop-bit cycle gives a back-to-back next frame.
        if (tx_load) begin
            tx_active_d = 1'b1;
            bit_d       = 4'd0;
            baud_d      = '0;
            shift_d     = {1'b1, tx_byte, 1'b0};
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        pix_d        = pix_q;
        tx_load      = 1'b0;
        tx_byte      = HEADER;
        spram_rd_req = 1'b0;
        done         = 1'b0;
        cnt_inc      = cnt_q + 16'd1;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHdr;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            StHdr: begin
                if (!tx_active_q) begin
                    tx_load = 1'b1;
                    tx_byte = HEADER;
                end else if (tx_done) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                spram_rd_req = 1'b1;
                if (spram_rd_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                pix_d   = spram_rd_data;
                state_d = StSendHi;
            end
            StSendHi: begin
                if (!tx_active_q) begin
                    tx_load = 1'b1;
                    tx_byte = {4'h0, pix_q[11:8]};
                end else if (tx_done) begin
                    tx_load = 1'b1;
                    tx_byte = pix_q[7:0];
                    state_d = StSendLo;
                end
            end
            StSendLo: begin
                if (tx_done) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == NPixL) begin
                        state_d = StFin;
                    end else begin
                        addr_d  = addr_q + 15'd1;
                        state_d = StFetch;
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            pix_q       <= '0;
            tx_active_q <= 1'b0;
            bit_q       <= '0;
            baud_q      <= '0;
            shift_q     <= '1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pix_q       <= pix_d;
            tx_active_q <= tx_active_d;
            bit_q       <= bit_d;
            baud_q      <= baud_d;
            shift_q     <= shift_d;
        end
    end

    assign uart_tx    = tx_active_q ? shift_q[0] : 1'b1;
    assign busy       = (state_q != StIdle) && (state_q != StFin);
    assign spram_addr = addr_q;
    assign pix_cnt    = cnt_q[14:0];

endmodule

// File: tb/tb_image_uart_dump.sv
// Bench for image_uart_dump: UART-decoding reference model checked every cycle, plus a
// single-pixel instance whose line is checked against literal bit patterns.
`timescale 1ns / 1ps

module tb_image_uart_dump;

    localparam int unsigned W     = 3;
    localparam int unsigned H     = 2;
    localparam int unsigned NPIX  = W * H;
    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 10 * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, gnt, req, tx, busy, done;
    logic [11:0] rd_data;
    logic [14:0] addr, pix_cnt;

    logic        rst1, start1, req1, tx1, busy1, done1;
    logic [14:0] addr1, pix_cnt1;

    image_uart_dump #(.W(W), .H(H), .CLK_DIV(DIV), .HEADER(8'hA5)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .spram_rd_req  (req),
        .spram_rd_gnt  (gnt),
        .spram_addr    (addr),
        .spram_rd_data (rd_data),
        .uart_tx       (tx),
        .busy          (busy),
        .done          (done),
        .pix_cnt       (pix_cnt)
    );

    image_uart_dump #(.W(1), .H(1), .CLK_DIV(DIV), .HEADER(8'hA5)) u_dut1 (
        .clk           (clk),
        .rst           (rst1),
        .start         (start1),
        .spram_rd_req  (req1),
        .spram_rd_gnt  (1'b1),
        .spram_addr    (addr1),
        .spram_rd_data (12'hF5A),
        .uart_tx       (tx1),
        .busy          (busy1),
        .done          (done1),
        .pix_cnt       (pix_cnt1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [11:0] mem [NPIX];
    int          gnt_mode = 0;   // 0: always grant, 1: random, 2: withhold

    // RAM/arbiter: data is only meaningful the cycle after a grant, garbage otherwise.
    initial begin
        logic        hit;
        logic [14:0] a;
        gnt     = 1'b1;
        rd_data = '0;
        forever begin
            @(negedge clk);
            hit = req && gnt;
            a   = addr;
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       gnt = 1'b1;
                1:       gnt = ($urandom_range(0, 2) != 0);
                default: gnt = 1'b0;
            endcase
            rd_data = (hit && int'(a) < NPIX) ? mem[int'(a)] : 12'($urandom);
        end
    end

    // Reference model state
    bit          m_busy = 0;
    bit          m_done = 0;
    logic [31:0] exp_pix = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  log_b[$];
    bit          rx_act = 0;
    int          rx_cyc = 0;
    int          rx_idx = 0;
    int          gap = 0;
    int          done_cnt = 0;
    logic [9:0]  rx_bits;
    logic        cur_bit;

    always @(negedge clk) begin
        bit         was_busy, was_done, fin_now;
        int         ph, bi;
        logic [7:0] eb, rb;
        was_busy = m_busy;
        was_done = m_done;
        fin_now  = 0;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("pix_cnt", pix_cnt, exp_pix);
        if (!m_busy) begin
            chk("idle_line", tx, 1);
            chk("idle_req", req, 0);
        end
        if (req) begin
            chk("req_addr", addr, exp_pix);
            chk("req_line_high", tx, 1);
        end
        if (done) done_cnt++;

        if (!rx_act && tx == 1'b0) begin
            rx_act = 1;
            rx_cyc = 0;
            chk("frame_expected", exp_q.size() > 0, 1);
            if (rx_idx > 0) begin
                if (rx_idx % 2 == 1) chk("pixel_gap_ge3", gap >= 3, 1);
                else                 chk("hi_lo_gap", gap, 0);
            end
        end else if (!rx_act) begin
            gap++;
        end
        if (rx_act) begin
            ph = rx_cyc % DIV;
            bi = rx_cyc / DIV;
            if (ph == 0) cur_bit = tx;
            else         chk("bit_stable", tx, cur_bit);
            if (ph == DIV / 2) rx_bits[bi] = tx;
            if (rx_cyc == FRAME - 1) begin
                rb = rx_bits[8:1];
                chk("start_bit", rx_bits[0], 0);
                chk("stop_bit", rx_bits[9], 1);
                if (exp_q.size() > 0) begin
                    eb = exp_q.pop_front();
                    chk("byte", rb, eb);
                end
                log_b.push_back(rb);
                if (rx_idx > 0 && rx_idx % 2 == 0) exp_pix++;
                rx_idx++;
                rx_act = 0;
                gap    = 0;
                if (m_busy && exp_q.size() == 0) begin
                    m_busy  = 0;
                    fin_now = 1;
                end
            end else begin
                rx_cyc++;
            end
        end

        m_done = fin_now;
        if (rst) begin
            m_busy  = 0;
            m_done  = 0;
            exp_pix = 0;
            exp_q.delete();
            rx_act  = 0;
            rx_idx  = 0;
            gap     = 0;
        end else if (start && !was_busy && !was_done) begin
            m_busy  = 1;
            exp_pix = 0;
            rx_idx  = 0;
            gap     = 0;
            exp_q.delete();
            log_b.delete();
            exp_q.push_back(8'hA5);
            for (int k = 0; k < NPIX; k++) begin
                exp_q.push_back({4'h0, mem[k][11:8]});
                exp_q.push_back(mem[k][7:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            tick();
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
    endtask

    task automatic randomize_mem();
        for (int k = 0; k < NPIX; k++) mem[k] = 12'($urandom);
    endtask

    logic       samp [250];
    logic [0:9] hdr_t, hi_t, lo_t;
    logic [7:0] lit_b [13];

    initial begin
        int  t0, t1, d1;
        bit  got;
        rst    = 1'b1;
        rst1   = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        for (int k = 0; k < NPIX; k++) mem[k] = 12'(12'h100 * k + 12'h0AB);
        repeat (3) tick();
        rst  = 1'b0;
        rst1 = 1'b0;
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_pix_cnt", pix_cnt, 0);

        // Single pixel 12'hF5A: literal line patterns at bit centres.
        hdr_t = 10'b0101001011;
        hi_t  = 10'b0111100001;
        lo_t  = 10'b0010110101;
        d1 = 0;
        start1 = 1'b1;
        for (int c = 0; c < 250; c++) begin
            tick();
            start1  = 1'b0;
            samp[c] = tx1;
            if (done1) d1++;
        end
        t0 = 100;
        for (int j = 99; j >= 0; j--) if (samp[j] == 1'b0) t0 = j;
        chk("p1_hdr_found", t0 < 100, 1);
        t1 = 170;
        for (int j = 169; j >= t0 + FRAME; j--) if (samp[j] == 1'b0) t1 = j;
        chk("p1_hi_found", t1 < 170, 1);
        chk("p1_hdr_hi_gap_ge3", t1 - (t0 + FRAME) >= 3, 1);
        for (int i = 0; i < 10; i++) begin
            chk("p1_hdr_bit", samp[t0 + 4 * i + 2], hdr_t[i]);
            chk("p1_hi_bit", samp[t1 + 4 * i + 2], hi_t[i]);
            chk("p1_lo_bit", samp[t1 + FRAME + 4 * i + 2], lo_t[i]);
        end
        chk("p1_done_count", d1, 1);
        chk("p1_pix_cnt", pix_cnt1, 1);

        // Full dump, grant tied high, known pattern.
        gnt_mode = 0;
        done_cnt = 0;
        pulse_start();
        wait_done(3000);
        tick();
        chk("dump_pix_cnt", pix_cnt, 6);
        chk("dump_frames", log_b.size(), 13);
        chk("dump_done_count", done_cnt, 1);
        lit_b = '{8'hA5, 8'h00, 8'hAB, 8'h01, 8'hAB, 8'h02, 8'hAB,
                  8'h03, 8'hAB, 8'h04, 8'hAB, 8'h05, 8'hAB};
        for (int i = 0; i < 13; i++)
            chk("dump_literal_byte", (i < log_b.size()) ? log_b[i] : 8'hxx, lit_b[i]);

        // Grant stall on pixel 2, plus starts while busy and in the done cycle.
        done_cnt = 0;
        pulse_start();
        repeat (10) tick();
        pulse_start();
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            tick();
            if (rx_idx == 4) got = 1;
        end
        chk("reach_pixel1_lo", got, 1);
        gnt_mode = 2;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (req) got = 1;
        end
        chk("stall_req_seen", got, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_req", req, 1);
            chk("stall_addr", addr, 2);
            chk("stall_line", tx, 1);
        end
        gnt_mode = 0;
        wait_done(3000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("stall_frames", log_b.size(), 13);
        chk("stall_done_count", done_cnt, 1);
        chk("stall_busy_after", busy, 0);
        chk("stall_pix_hold", pix_cnt, 6);

        // Reset during d3 of pixel 1's LO byte, then a fresh dump.
        gnt_mode = 1;
        randomize_mem();
        pulse_start();
        got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            tick();
            if (rx_act && rx_idx == 4 && rx_cyc == 17) got = 1;
        end
        chk("reach_lo_d3", got, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_req", req, 0);
        randomize_mem();
        pulse_start();
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (req) got = 1;
            else     tick();
        end
        chk("restart_req_seen", got, 1);
        chk("restart_addr", addr, 0);
        wait_done(4000);
        chk("restart_header", (log_b.size() > 0) ? log_b[0] : 8'hxx, 8'hA5);
        chk("restart_frames", log_b.size(), 13);

        // Randomized dumps.
        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            pulse_start();
            wait_done(4000);
            tick();
            chk("rand_frames", log_b.size(), 13);
            chk("rand_pix_cnt", pix_cnt, 6);
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/image_uart_dump.md
Name: image_uart_dump

Overview:
- Readback path of the photo-frame image store; the transmit counterpart of the UART-receive-to-SPRAM write path.
- On a start pulse, reads every stored 12-bit pixel from the single-port image RAM in address order.
- Sends each pixel to the host over a UART 8N1 line, preceded by a one-byte header.
- Competes with the VGA reader for the RAM port through a request/grant handshake.

Parameters:
- W, 3, image width in pixels.
- H, 2, image height in pixels; W*H must be in the range 1..32768.
- CLK_DIV, 434, clk cycles per UART bit; minimum 2.
- HEADER, 8'hA5, header byte sent before pixel data.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a dump; ignored while busy=1.
- spram_rd_req  output  1  RAM read request.
- spram_rd_gnt  input  1  RAM read grant from the arbiter.
- spram_addr  output  15  pixel address; valid while spram_rd_req=1.
- spram_rd_data  input  12  RAM read data; valid the cycle after the grant cycle.
- uart_tx  output  1  serial line; idles high.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last stop bit.
- pix_cnt  output  15  number of pixels fully transmitted in the current dump.

Behaviour:
- Reset values: uart_tx=1, busy=0, done=0, spram_rd_req=0, spram_addr=0, pix_cnt=0, FSM in IDLE.
- Reset mid-operation aborts the dump. uart_tx returns high on the cycle after rst is sampled, even mid-bit. No partial-frame completion.
- FSM states: IDLE, HDR, FETCH, WAIT, SEND_HI, SEND_LO, FIN.
- IDLE: start=1 -> HDR; busy goes 1 in the next cycle; pix_cnt and spram_addr cleared to 0.
- HDR: transmit HEADER, then go to FETCH.
- FETCH: hold spram_rd_req=1 with spram_addr = current pixel index.
  - In the first cycle spram_rd_gnt=1, the address is taken; spram_rd_req drops the next cycle.
  - Waiting for the grant is unbounded; the request and address must stay stable throughout.
- WAIT: capture spram_rd_data into the pixel register (exactly 1 cycle after the grant), then go to SEND_HI.
- SEND_HI: transmit the byte {4'h0, pix[11:8]}.
- SEND_LO: transmit the byte pix[7:0].
  - When its stop bit ends, pix_cnt increments.
  - If pix_cnt (new value) == W*H -> FIN; otherwise spram_addr increments and the FSM goes to FETCH.
- FIN: done=1 for one cycle, busy=0 in that same cycle; return to IDLE. A start in the FIN cycle is ignored.
- Byte serializer (8N1, LSB first):
  - The frame begins on the cycle after the byte is loaded.
  - Start bit (0), then d0..d7, then stop bit (1); each bit lasts exactly CLK_DIV cycles, so a frame is 10*CLK_DIV cycles.
  - Baud counter counts 0..CLK_DIV-1 and restarts at every frame; no fractional accumulation.
- Byte spacing:
  - HI to LO of the same pixel is back-to-back: the LO start bit begins the cycle after the HI stop bit ends.
  - Between pixels, the line stays high for the fetch/grant/capture gap, which is at least 3 cycles.
- Total bytes per dump: 1 + 2*W*H.
- pix_cnt holds its final value after done until the next accepted start.

Test Plan:
- Reset check: CLK_DIV=4, W=3, H=2, RAM addr k holds 12'h100*k+12'h0AB, spram_rd_gnt tied 1, pulse start. Required: decoded bytes A5, 00,AB, 01,AB, 02,AB, 03,AB, 04,AB, 05,AB; pix_cnt reaches 6; done pulses once; 13 frames of exactly 40 cycles each.
- Bit timing: single pixel 12'hF5A (W=H=1, CLK_DIV=4). Required: line samples at bit centres give 0,1,0,1,0,0,1,0,1,1 for the A5 header, then 00001111 for the HI byte, then 01011010 LSB-first for the LO byte; HI and LO frames are contiguous.
- Grant stall: hold spram_rd_gnt=0 for 20 cycles during FETCH of pixel 2. Required: spram_rd_req and spram_addr=2 stay stable; uart_tx stays 1; data is captured 1 cycle after the grant; output bytes are unchanged.
- Start while busy: pulse start mid-dump and again in the done cycle. Required: still exactly 13 frames; no second dump.
- Reset mid-bit: assert rst during d3 of pixel 1's LO byte. Required: uart_tx=1, busy=0, spram_rd_req=0 the next cycle; a following start begins with a fresh A5 and address 0.
